// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state codes and counter sizing.
package arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, with start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned SW = WIDTH - 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [SW-1:0]    sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             br_next;
  logic             last;
  logic             load;

  full_subtractor u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .bi (br),
    .d  (diff),
    .bo (br_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign load = start && (state == ST_IDLE || state == ST_DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE may reload directly for back-to-back operation
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last)  state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Operand shifters, borrow chain, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
      d   <= '0;
      bo  <= 1'b0;
      ov  <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == ST_SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= (sr >> 1) | (SW'(diff) << (SW - 1));
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        d  <= {diff, sr};
        bo <= br_next;
        ov <= (sa[0] != sb[0]) && (diff != sa[0]);
      end
    end
  end

endmodule
